v2f_alu_arbiter: RTL

//  Shares one combinational v2f arithmetic datapath (add/sub/mul/div/mod/logic/shift/compare)

---
 rtl/v2f_alu_pkg.sv | 27 ++
 rtl/v2f_alu_core.sv | 47 ++++
 rtl/v2f_alu_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/v2f_alu_pkg.sv
// Shared opcode encoding for the v2f arithmetic datapath and its arbiter.
package v2f_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
  localparam logic [OP_W-1:0] OP_MOD  = 4'd4;
  localparam logic [OP_W-1:0] OP_AND  = 4'd5;
  localparam logic [OP_W-1:0] OP_OR   = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd9;
  localparam logic [OP_W-1:0] OP_SSHR = 4'd10;
  localparam logic [OP_W-1:0] OP_LT   = 4'd11;
  localparam logic [OP_W-1:0] OP_GT   = 4'd12;
  localparam logic [OP_W-1:0] OP_EQ   = 4'd13;
  localparam logic [OP_W-1:0] OP_NE   = 4'd14;
  localparam logic [OP_W-1:0] OP_ILL  = 4'd15;

  function automatic logic op_needs_divisor(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/v2f_alu_core.sv
// Stateless v2f arithmetic datapath: decodes op and produces result plus error flag.
module v2f_alu_core
  import v2f_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;
  logic            b_zero;

  assign sh     = b[SH_W-1:0];
  assign b_zero = (b == '0);

  // Signed divide truncates toward zero and the remainder takes the sign of a.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_DIV:  if (!b_zero) y = $signed(a) / $signed(b);
      OP_MOD:  if (!b_zero) y = $signed(a) % $signed(b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_SSHR: y = $signed(a) >>> sh;
      OP_LT:   y[0] = ($signed(a) < $signed(b));
      OP_GT:   y[0] = ($signed(a) > $signed(b));
      OP_EQ:   y[0] = (a == b);
      OP_NE:   y[0] = (a != b);
      default: err = 1'b1;
    endcase
    if (op_needs_divisor(op) && b_zero) err = 1'b1;
  end

endmodule

// File: rtl/v2f_alu_arbiter.sv
// Round-robin sharing of one v2f ALU among N_REQ requesters, with a fixed-latency
// result pipeline and a per-requester hold slot for each result.
module v2f_alu_arbiter
  import v2f_alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [N_REQ*WIDTH-1:0] rsp_data,
  output logic [N_REQ-1:0]       rsp_err
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] idx;
    logic [WIDTH-1:0] data;
    logic             err;
  } pipe_entry_t;

  logic [OP_W-1:0]  op_arr [N_REQ];
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] hold_data [N_REQ];

  logic [N_REQ-1:0] outstanding;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] hold_valid;
  logic [N_REQ-1:0] hold_err;
  logic [N_REQ-1:0] rsp_fire;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand_idx;
  logic [PTR_W:0]   cand;
  logic             grant_any;
  logic [WIDTH-1:0] alu_y;
  logic             alu_err;
  pipe_entry_t      issue;
  pipe_entry_t      retire;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign op_arr[i] = req_op[i*OP_W +: OP_W];
    assign a_arr[i]  = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    assign rsp_data[i*WIDTH +: WIDTH] = hold_data[i];
  end

  // A requester stays ineligible from its grant until the edge after its result is taken.
  assign eligible  = req_valid & ~outstanding;
  assign rsp_fire  = hold_valid & rsp_ready;
  assign req_ready = grant;
  assign rsp_valid = hold_valid;
  assign rsp_err   = hold_err;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    if (rst_n) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
        if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
        cand_idx = cand[PTR_W-1:0];
        if (!grant_any && eligible[cand_idx]) begin
          grant_any       = 1'b1;
          grant_idx       = cand_idx;
          grant[cand_idx] = 1'b1;
        end
      end
    end
  end

  v2f_alu_core #(.WIDTH(WIDTH)) u_core (
    .op  (op_arr[grant_idx]),
    .a   (a_arr[grant_idx]),
    .b   (b_arr[grant_idx]),
    .y   (alu_y),
    .err (alu_err)
  );

  always_comb begin
    issue.valid = grant_any;
    issue.idx   = grant_idx;
    issue.data  = alu_y;
    issue.err   = alu_err;
  end

  // The hold-slot load is the last of the LATENCY register stages.
  if (LATENCY == 1) begin : g_direct
    assign retire = issue;
  end else begin : g_pipe
    pipe_entry_t stage [LATENCY-1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < LATENCY-1; k++) stage[k] <= '0;
      end else begin
        stage[0] <= issue;
        for (int k = 1; k < LATENCY-1; k++) stage[k] <= stage[k-1];
      end
    end

    assign retire = stage[LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
      hold_valid  <= '0;
      hold_err    <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < N_REQ; i++) hold_data[i] <= '0;
    end else begin
      outstanding <= (outstanding & ~rsp_fire) | grant;
      if (grant_any) begin
        rr_ptr <= (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (retire.valid && retire.idx == PTR_W'(i)) begin
          hold_valid[i] <= 1'b1;
          hold_data[i]  <= retire.data;
          hold_err[i]   <= retire.err;
        end else if (rsp_fire[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
